// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: mode encodings and saturating-increment helper for latch_bank
package latch_bank_pkg;
  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'd0,
    MODE_EDGE   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = {64{1'b1}} >> (64 - w);
    return (v == max_v) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/latch_bank_ch.sv
// latch_bank_ch: one capture channel with mode action, change pulse and saturating change counter
module latch_bank_ch
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_upd,
  output logic [CNTW-1:0]  o_cnt
);
  logic [WIDTH-1:0] r_q;
  logic             r_en_prev;
  logic             r_upd;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_nq;
  logic             w_chg;
  logic [CNTW-1:0]  w_cnt_inc;
  // next value chosen by the global mode; anything not selected holds
  always_comb begin
    w_nq = (i_mode == MODE_FOLLOW && i_en)               ? i_d :
           (i_mode == MODE_EDGE && i_en && !r_en_prev)   ? i_d :
           (i_mode == MODE_TOGGLE && i_en)               ? r_q ^ i_d : r_q;
    w_chg = w_nq != r_q;
    w_cnt_inc = CNTW'(sat_inc(64'(r_cnt), CNTW));
  end
  // state update: reset beats clear beats mode action; en history always tracks en
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_en_prev <= 1'b0;
      r_upd     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_en_prev <= i_en;
      if (i_clr) begin
        r_q   <= '0;
        r_upd <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_q   <= w_nq;
        r_upd <= w_chg;
        if (w_chg) r_cnt <= w_cnt_inc;
      end
    end
  end
  assign o_q   = r_q;
  assign o_upd = r_upd;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/latch_bank.sv
// latch_bank: CH independent clocked capture channels with follow/edge/toggle/freeze modes
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [CH*WIDTH-1:0] d,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       clr,
  output logic [CH*WIDTH-1:0] q,
  output logic [CH-1:0]       upd,
  output logic [CH*CNTW-1:0]  cnt
);
  mode_e w_mode;
  assign w_mode = mode_e'(mode);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    latch_bank_ch #(.WIDTH(WIDTH), .CNTW(CNTW)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_mode (w_mode),
      .i_d    (d[i*WIDTH +: WIDTH]),
      .i_en   (en[i]),
      .i_clr  (clr[i]),
      .o_q    (q[i*WIDTH +: WIDTH]),
      .o_upd  (upd[i]),
      .o_cnt  (cnt[i*CNTW +: CNTW])
    );
  end
endmodule
